// File: rtl/fifo_pkg.sv
// Types and defaults shared by the async FIFO read-side logic.
package fifo_pkg;

    localparam int unsigned FIFO_DSIZE = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_port.sv
// Read-side consumer for the async FIFO: 2-entry skid buffer toward a valid/ready
// sink, with flush and a wrapping count of completed downstream transfers.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] pop_count
);

    rd_state_t        state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    // Reset gates the pop so FIFO entries survive a read-domain reset.
    assign rinc      = rrst_n & ~rempty & ~flush & (state_q != TWO);
    assign push      = rinc;
    assign out_valid = (state_q != EMPTY);
    assign pop       = out_valid & out_ready;
    assign out_data  = head_q;
    assign pop_count = cnt_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = pop ? cnt_q + CNT_W'(1) : cnt_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        head_d  = rdata;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = rdata;
                    end else if (push) begin
                        state_d = TWO;
                        tail_d  = rdata;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_port.sv
// Scoreboard bench for fifo_rd_port driven by a behavioural FIFO model.
`timescale 1ns/100ps
module tb_fifo_rd_port;
    import fifo_pkg::*;

    localparam int unsigned DW = 5;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic [DW-1:0] rdata;
    logic          rempty;
    logic          rinc, rinc_w;
    logic [DW-1:0] out_data, out_data_w;
    logic          out_valid, out_valid_w;
    logic          out_ready;
    logic          flush;
    logic [15:0]   pop_count;
    logic [3:0]    pop_count_w;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            pend = 1'b0;

    fifo_rd_port #(.DSIZE(DW), .CNT_W(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .pop_count(pop_count)
    );

    fifo_rd_port #(.DSIZE(DW), .CNT_W(4)) dut_w (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc_w),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .flush(flush), .pop_count(pop_count_w)
    );

    always #5 rclk = ~rclk;

    function automatic void refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    // FIFO model: pop decided from the settled rinc, applied just after the edge.
    always @(negedge rclk) pend = rinc;
    always @(posedge rclk) begin
        #1;
        if (pend) begin
            void'(fifo_q.pop_front());
            pend = 1'b0;
        end
        refresh();
    end

    always @(negedge rclk) begin
        logic [DW-1:0] e;
        if ((out_valid || out_valid_w) && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected: got data=%0d, expected no transfer", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e || out_data_w !== e || out_valid !== 1'b1 || out_valid_w !== 1'b1) begin
                    failures++;
                    $display("FAIL xfer_data: got %0d/%0d valid %b/%b, expected %0d valid 1/1",
                             out_data, out_data_w, out_valid, out_valid_w, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic preload(input int lo, input int hi, input bit add_exp);
        for (int v = lo; v <= hi; v++) begin
            fifo_q.push_back(DW'(v));
            if (add_exp) exp_q.push_back(DW'(v));
        end
        refresh();
    endtask

    task automatic apply_reset();
        tick();
        rrst_n = 1'b0;
        flush  = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n_rinc, n_val, run, max_run;
        rrst_n    = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        refresh();

        // Reset state
        @(negedge rclk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_count", 32'(pop_count), 0);
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_count_w", 32'(pop_count_w), 0);

        // Empty FIFO
        tick();
        out_ready = 1'b1;
        rrst_n    = 1'b1;
        repeat (20) begin
            @(negedge rclk);
            chk("empty_rinc", 32'(rinc | rinc_w), 0);
            chk("empty_valid", 32'(out_valid), 0);
            chk("empty_count", 32'(pop_count), 0);
        end

        // Streaming 0..4
        tick();
        preload(0, 4, 1);
        n_rinc = 0; n_val = 0; run = 0; max_run = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            if (i == 0) begin
                chk("lat_rinc", 32'(rinc), 1);
                chk("lat_valid0", 32'(out_valid), 0);
            end
            if (i == 1) begin
                chk("lat_valid1", 32'(out_valid), 1);
                chk("lat_data1", 32'(out_data), 0);
            end
            n_rinc += int'(rinc);
            n_val  += int'(out_valid);
            run     = rinc ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        chk("stream_rinc_cycles", 32'(n_rinc), 5);
        chk("stream_rinc_run", 32'(max_run), 5);
        chk("stream_valid_cycles", 32'(n_val), 5);
        chk("stream_count", 32'(pop_count), 5);
        chk("stream_valid_end", 32'(out_valid), 0);
        tick();
        chk("stream_drained", 32'(exp_q.size()), 0);

        // Backpressure with 0..9
        out_ready = 1'b0;
        apply_reset();
        rrst_n = 1'b1;
        tick();
        preload(0, 9, 1);
        n_rinc = 0;
        repeat (6) begin
            @(negedge rclk);
            n_rinc += int'(rinc);
        end
        chk("bp_rinc_cycles", 32'(n_rinc), 2);
        chk("bp_state", 32'(dut.state_q), 32'(TWO));
        chk("bp_data", 32'(out_data), 0);
        chk("bp_valid", 32'(out_valid), 1);
        tick();
        out_ready = 1'b1;
        n_val = 0;
        repeat (10) begin
            @(negedge rclk);
            n_val += int'(out_valid && out_ready);
        end
        chk("bp_release_xfers", 32'(n_val), 10);
        @(negedge rclk);
        chk("bp_count", 32'(pop_count), 10);
        chk("bp_valid_end", 32'(out_valid), 0);
        tick();
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Flush while holding 3,4 with 5..7 still in the FIFO
        out_ready = 1'b0;
        apply_reset();
        rrst_n = 1'b1;
        tick();
        preload(3, 7, 0);
        for (int v = 5; v <= 7; v++) exp_q.push_back(DW'(v));
        repeat (3) @(negedge rclk);
        chk("fl_state", 32'(dut.state_q), 32'(TWO));
        chk("fl_head", 32'(out_data), 3);
        tick();
        flush = 1'b1;
        @(negedge rclk);
        chk("fl_rinc", 32'(rinc | rinc_w), 0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge rclk);
        chk("fl_valid_after", 32'(out_valid), 0);
        repeat (6) @(negedge rclk);
        chk("fl_count", 32'(pop_count), 3);
        tick();
        chk("fl_drained", 32'(exp_q.size()), 0);

        // Reset mid-stream: entry 2 is lost in the buffer, 3.. stay in the FIFO
        apply_reset();
        rrst_n = 1'b1;
        tick();
        preload(0, 7, 0);
        exp_q.push_back(DW'(0));
        exp_q.push_back(DW'(1));
        for (int v = 3; v <= 7; v++) exp_q.push_back(DW'(v));
        tick(); tick(); tick();
        chk("mid_count_pre", 32'(pop_count), 2);
        rrst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_count", 32'(pop_count), 0);
        chk("mid_rinc", 32'(rinc | rinc_w), 0);
        tick(); tick();
        rrst_n = 1'b1;
        repeat (8) @(negedge rclk);
        chk("mid_count_end", 32'(pop_count), 5);
        tick();
        chk("mid_drained", 32'(exp_q.size()), 0);
        chk("mid_fifo_empty", 32'(fifo_q.size()), 0);

        // Counter wrap on the 4-bit instance
        apply_reset();
        rrst_n = 1'b1;
        tick();
        preload(10, 26, 1);
        repeat (20) @(negedge rclk);
        chk("wrap_count_w", 32'(pop_count_w), 1);
        chk("wrap_count", 32'(pop_count), 17);
        tick();
        chk("wrap_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
